// File: rtl/iter_sched_if.sv
// Bundle of requester, memory and op-unit signals around the iter_sched engine.
// slave = the scheduler; master = requesters plus value store and op unit.
interface iter_sched_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_s_index;
    logic [32*NREQ-1:0]   req_e_index;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [31:0]          rsp_value;
    logic                 rsp_err;
    logic                 mem_rd;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_data;
    logic                 op_clr;
    logic                 op_en;
    logic [31:0]          op_data;
    logic [31:0]          op_result;
    logic                 busy;

    modport master (
        output req_valid, req_s_index, req_e_index, mem_data, op_result,
        input  req_ready, rsp_valid, rsp_value, rsp_err, mem_rd, mem_addr,
               op_clr, op_en, op_data, busy
    );

    modport slave (
        input  req_valid, req_s_index, req_e_index, mem_data, op_result,
        output req_ready, rsp_valid, rsp_value, rsp_err, mem_rd, mem_addr,
               op_clr, op_en, op_data, busy
    );
endinterface

// File: rtl/iter_sched.sv
// Shares one window-iteration engine (memory read port + reducing op unit) among NREQ requesters.
// Define ITER_SCHED_RR_EN for round-robin arbitration; otherwise lowest asserted index wins.
module iter_sched #(
    parameter int NREQ = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    iter_sched_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CAPT, S_RESP, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     e_q, e_d;
    logic [31:0]     val_q, val_d;
    logic            op_en_q;

    logic [31:0]     s_arr [NREQ];
    logic [31:0]     e_arr [NREQ];

    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            accept;

    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] rsp_valid;
    logic            rsp_err;
    logic            mem_rd;
    logic [31:0]     mem_addr;
    logic            op_clr;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign s_arr[gi] = bus.req_s_index[32*gi +: 32];
        assign e_arr[gi] = bus.req_e_index[32*gi +: 32];
    end

    function automatic logic [NREQ-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign accept = (state_q == S_IDLE) && win_found;

`ifdef ITER_SCHED_RR_EN
    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] ptr;

    // Search starts one past the previous winner so every requester gets a turn.
    assign ptr = (last_grant_q == IW'(NREQ - 1)) ? '0 : last_grant_q + 1'b1;

    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!win_found && bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_grant_q <= IW'(NREQ - 1);
        end else if (accept) begin
            last_grant_q <= win_idx;
        end
    end
`else
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        e_d       = e_q;
        val_d     = val_q;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        op_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready = to_onehot(win_idx);
                    owner_d   = win_idx;
                    cnt_d     = s_arr[win_idx];
                    e_d       = e_arr[win_idx];
                    state_d   = (e_arr[win_idx] < s_arr[win_idx]) ? S_ERR : S_CLR;
                end
            end
            S_CLR: begin
                op_clr  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                mem_rd   = 1'b1;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + 32'd1;
                if (cnt_q == e_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_CAPT;
            end
            // op_result reflects the last op_en only from this cycle on.
            S_CAPT: begin
                val_d   = bus.op_result;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = to_onehot(owner_q);
                state_d   = S_IDLE;
            end
            S_ERR: begin
                rsp_valid = to_onehot(owner_q);
                rsp_err   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            e_q     <= '0;
            val_q   <= '0;
            op_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            val_q   <= val_d;
            op_en_q <= mem_rd;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_value = (state_q == S_RESP) ? val_q : '0;
    assign bus.rsp_err   = rsp_err;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_addr  = mem_addr;
    assign bus.op_clr    = op_clr;
    assign bus.op_en     = op_en_q;
    assign bus.op_data   = bus.mem_data;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_iter_sched.sv
// Bench for iter_sched: value store and summing op unit modelled here; expected traces come
// from the accept-relative timing rules and a plain window sum.
module tb_iter_sched;
    localparam int NREQ = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    iter_sched_if #(.NREQ(NREQ)) bus ();
    iter_sched #(.NREQ(NREQ)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    logic [31:0] mem [256];
    logic [31:0] acc;

    always @(posedge Clk) bus.mem_data <= mem[bus.mem_addr[7:0]];
    always @(posedge Clk) begin
        if (bus.op_clr)     acc <= 32'd0;
        else if (bus.op_en) acc <= acc + bus.op_data;
    end
    assign bus.op_result = acc;

    int total = 0;
    int bad   = 0;

    logic [12:0] obs_ctl  [64];
    logic [31:0] obs_addr [64];
    logic [31:0] obs_val  [64];

    function automatic logic [12:0] pack_obs();
        return {bus.busy, bus.op_clr, bus.mem_rd, bus.op_en, bus.rsp_err, bus.rsp_valid, bus.req_ready};
    endfunction

    function automatic logic [31:0] win_sum(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] a;
        a = 32'd0;
        for (longint i = longint'(s); i <= longint'(e); i++) a = a + mem[8'(i)];
        return a;
    endfunction

    // Expected control word for cycle c after accept (c=0 is the accept cycle).
    function automatic logic [12:0] exp_ctl(input int r, input logic [31:0] s, input logic [31:0] e, input int c);
        logic bsy, clr, rd, en, err;
        logic [3:0] rv, rr;
        longint len;
        len = longint'(e) - longint'(s) + 1;
        bsy = 0; clr = 0; rd = 0; en = 0; err = 0; rv = 4'b0; rr = 4'b0;
        if (c == 0) rr = 4'b0001 << r;
        if (e < s) begin
            if (c == 1) begin bsy = 1; rv = 4'b0001 << r; err = 1; end
        end else begin
            bsy = (c >= 1) && (c <= len + 4);
            clr = (c == 1);
            rd  = (c >= 2) && (c <= len + 1);
            en  = (c >= 3) && (c <= len + 2);
            if (c == len + 4) rv = 4'b0001 << r;
        end
        return {bsy, clr, rd, en, err, rv, rr};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] s, input logic [31:0] e, input int c);
        longint len;
        len = longint'(e) - longint'(s) + 1;
        if (e >= s && c >= 2 && c <= len + 1) return s + 32'(c - 2);
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_val(input logic [31:0] s, input logic [31:0] e, input int c);
        if (e >= s && longint'(c) == longint'(e) - longint'(s) + 5) return win_sum(s, e);
        return 32'd0;
    endfunction

    function automatic int job_cycles(input logic [31:0] s, input logic [31:0] e);
        if (e < s) return 3;
        return int'(e - s) + 6;
    endfunction

    task automatic job_trace(input int r, input logic [31:0] s, input logic [31:0] e, input int n);
        @(negedge Clk);
        bus.req_s_index[32*r +: 32] = s;
        bus.req_e_index[32*r +: 32] = e;
        bus.req_valid = 4'b0001 << r;
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(negedge Clk);
                if (c == 1) bus.req_valid = '0;
            end
            #1;
            obs_ctl[c]  = pack_obs();
            obs_addr[c] = bus.mem_rd ? bus.mem_addr : 32'd0;
            obs_val[c]  = (|bus.rsp_valid) ? bus.rsp_value : 32'd0;
        end
    endtask

    task automatic test_reset();
        bus.req_valid   = '0;
        bus.req_s_index = '0;
        bus.req_e_index = '0;
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        total++;
        if ({pack_obs(), bus.mem_addr, bus.rsp_value} !== 77'd0) begin
            bad++;
            $display("FAIL reset got ctl=%b addr=%0d val=%0d want all zero", pack_obs(), bus.mem_addr, bus.rsp_value);
        end
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_windows();
        int          tr [3];
        logic [31:0] ts [3];
        logic [31:0] te [3];
        int n;
        tr = '{0, 0, 2}; ts = '{32'd10, 32'd7, 32'd20}; te = '{32'd13, 32'd7, 32'd19};
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
        mem[7] = 32'h55;
        for (int j = 0; j < 3; j++) begin
            n = job_cycles(ts[j], te[j]);
            job_trace(tr[j], ts[j], te[j], n);
            for (int c = 0; c < n; c++) begin
                total++;
                if (obs_ctl[c] !== exp_ctl(tr[j], ts[j], te[j], c)) begin
                    bad++;
                    $display("FAIL window%0d ctl c=%0d got=%b want=%b", j, c, obs_ctl[c], exp_ctl(tr[j], ts[j], te[j], c));
                end
                total++;
                if (obs_addr[c] !== exp_addr(ts[j], te[j], c)) begin
                    bad++;
                    $display("FAIL window%0d addr c=%0d got=%0d want=%0d", j, c, obs_addr[c], exp_addr(ts[j], te[j], c));
                end
                total++;
                if (obs_val[c] !== exp_val(ts[j], te[j], c)) begin
                    bad++;
                    $display("FAIL window%0d value c=%0d got=%0h want=%0h", j, c, obs_val[c], exp_val(ts[j], te[j], c));
                end
            end
            if (j == 0) begin
                total++;
                if (obs_val[8] !== 32'd46) begin bad++; $display("FAIL sum46 got=%0d want=46", obs_val[8]); end
            end
            if (j == 1) begin
                total++;
                if (obs_val[5] !== 32'h55) begin bad++; $display("FAIL len1 got=%0h want=55", obs_val[5]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int g3, r1, r3;
        logic [31:0] v1, v3;
        bit drop3;
        g3 = -1; r1 = -1; r3 = -1; v1 = 0; v3 = 0; drop3 = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        @(negedge Clk);
        bus.req_s_index[32*1 +: 32] = 32'd0; bus.req_e_index[32*1 +: 32] = 32'd2;
        bus.req_s_index[32*3 +: 32] = 32'd5; bus.req_e_index[32*3 +: 32] = 32'd5;
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) begin
                @(negedge Clk);
                if (c == 1) bus.req_valid = 4'b1000;
                if (drop3) bus.req_valid = 4'b0000;
            end
            #1;
            if (bus.req_ready[3] && g3 < 0) begin g3 = c; drop3 = 1; end
            if (bus.rsp_valid == 4'b0010) begin r1 = c; v1 = bus.rsp_value; end
            if (bus.rsp_valid == 4'b1000) begin r3 = c; v3 = bus.rsp_value; end
        end
        total++; if (r1 !== 7)  begin bad++; $display("FAIL b2b rsp1 cycle got=%0d want=7", r1); end
        total++; if (g3 !== 8)  begin bad++; $display("FAIL b2b grant3 cycle got=%0d want=8", g3); end
        total++; if (r3 !== 13) begin bad++; $display("FAIL b2b rsp3 cycle got=%0d want=13", r3); end
        total++; if (v1 !== win_sum(0, 2)) begin bad++; $display("FAIL b2b val1 got=%0h want=%0h", v1, win_sum(0, 2)); end
        total++; if (v3 !== win_sum(5, 5)) begin bad++; $display("FAIL b2b val3 got=%0h want=%0h", v3, win_sum(5, 5)); end
    endtask

    task automatic test_withdraw();
        logic [12:0] o;
        @(negedge Clk);
        bus.req_s_index[0 +: 32] = 32'd40; bus.req_e_index[0 +: 32] = 32'd43;
        bus.req_s_index[64 +: 32] = 32'd1; bus.req_e_index[64 +: 32] = 32'd1;
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(negedge Clk);
                if (c == 1) bus.req_valid = 4'b0000;
                if (c == 2) bus.req_valid = 4'b0100;
                if (c == 6) bus.req_valid = 4'b0000;
            end
            #1;
            o = pack_obs();
            total++;
            if (o !== exp_ctl(0, 32'd40, 32'd43, c)) begin
                bad++;
                $display("FAIL withdraw c=%0d got=%b want=%b", c, o, exp_ctl(0, 32'd40, 32'd43, c));
            end
        end
    endtask

    task automatic test_arb();
        int gi_seen [5];
        int gc_seen [5];
        int ng, exp_g, w;
        ng = 0;
        @(negedge Clk); Rst = 1'b0;
        @(negedge Clk); Rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_s_index[32*i +: 32] = 32'(8 + i);
            bus.req_e_index[32*i +: 32] = 32'(8 + i);
        end
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge Clk);
            #1;
            if (bus.req_ready != 4'b0 && ng < 5) begin
                total++;
                if (!$onehot(bus.req_ready)) begin bad++; $display("FAIL arb onehot got=%b want=one-hot", bus.req_ready); end
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gi_seen[ng] = i;
                gc_seen[ng] = c;
                ng++;
            end
        end
        total++;
        if (ng != 5) begin bad++; $display("FAIL arb grants got=%0d want=5", ng); end
        for (int k = 0; k < ng; k++) begin
`ifdef ITER_SCHED_RR_EN
            exp_g = k % NREQ;
`else
            exp_g = 0;
`endif
            total++;
            if (gi_seen[k] != exp_g) begin bad++; $display("FAIL arb order k=%0d got=%0d want=%0d", k, gi_seen[k], exp_g); end
            total++;
            if (gc_seen[k] != 6 * k) begin bad++; $display("FAIL arb cycle k=%0d got=%0d want=%0d", k, gc_seen[k], 6 * k); end
        end
        @(negedge Clk);
        bus.req_valid = '0;
        w = 0;
        while (bus.busy && w < 40) begin @(negedge Clk); w++; end
        #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL arb drain busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_rst_mid();
        int act;
        int n;
        act = 0;
        @(negedge Clk);
        bus.req_s_index[32 +: 32] = 32'd32; bus.req_e_index[32 +: 32] = 32'd47;
        bus.req_valid = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (c == 1) bus.req_valid = '0;
        end
        #2 Rst = 1'b0;
        #1;
        total++;
        if ({pack_obs(), bus.mem_addr, bus.rsp_value} !== 77'd0) begin
            bad++;
            $display("FAIL rst_mid outputs got ctl=%b addr=%0d val=%0d want all zero", pack_obs(), bus.mem_addr, bus.rsp_value);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk); #1;
            if (bus.rsp_valid != 4'b0 || bus.busy || bus.mem_rd) act++;
        end
        total++;
        if (act != 0) begin bad++; $display("FAIL rst_mid dropped job activity got=%0d want=0", act); end
        n = job_cycles(32'd32, 32'd47);
        job_trace(1, 32'd32, 32'd47, n);
        for (int c = 0; c < n; c++) begin
            total++;
            if (obs_ctl[c] !== exp_ctl(1, 32'd32, 32'd47, c)) begin
                bad++;
                $display("FAIL resubmit ctl c=%0d got=%b want=%b", c, obs_ctl[c], exp_ctl(1, 32'd32, 32'd47, c));
            end
            total++;
            if (obs_addr[c] !== exp_addr(32'd32, 32'd47, c)) begin
                bad++;
                $display("FAIL resubmit addr c=%0d got=%0d want=%0d", c, obs_addr[c], exp_addr(32'd32, 32'd47, c));
            end
            total++;
            if (obs_val[c] !== exp_val(32'd32, 32'd47, c)) begin
                bad++;
                $display("FAIL resubmit value c=%0d got=%0h want=%0h", c, obs_val[c], exp_val(32'd32, 32'd47, c));
            end
        end
    endtask

    task automatic test_random();
        int r, n;
        logic [31:0] s, e;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int j = 0; j < 20; j++) begin
            r = int'($urandom_range(0, NREQ - 1));
            s = 32'($urandom_range(1, 300));
            if ($urandom_range(0, 5) == 0) e = s - 32'($urandom_range(1, s));
            else                           e = s + 32'($urandom_range(0, 11));
            n = job_cycles(s, e);
            job_trace(r, s, e, n);
            for (int c = 0; c < n; c++) begin
                total++;
                if (obs_ctl[c] !== exp_ctl(r, s, e, c)) begin
                    bad++;
                    $display("FAIL random job%0d ctl c=%0d got=%b want=%b", j, c, obs_ctl[c], exp_ctl(r, s, e, c));
                end
                total++;
                if (obs_addr[c] !== exp_addr(s, e, c)) begin
                    bad++;
                    $display("FAIL random job%0d addr c=%0d got=%0d want=%0d", j, c, obs_addr[c], exp_addr(s, e, c));
                end
                total++;
                if (obs_val[c] !== exp_val(s, e, c)) begin
                    bad++;
                    $display("FAIL random job%0d value c=%0d got=%0h want=%0h", j, c, obs_val[c], exp_val(s, e, c));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_windows();
        test_back_to_back();
        test_withdraw();
        test_arb();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_sched.md
# iter_sched

Round-robin job scheduler that shares one window-iteration engine (value memory read port plus one reducing operation unit) among `NREQ` requesters. Each requester submits an inclusive index window `[s_index, e_index]`. The block arbitrates between requesters and clears the operation unit. It then streams the window's values from memory into the operation and returns the final operation result to the granted requester with a one-cycle response pulse. It sits between the predictor's feature-extraction clients and the shared value store and op unit.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `Clk`  in  1  clock, all logic on posedge
- `Rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  requester i has a job pending
- `req_s_index`  in  32*NREQ  start index, requester i at bits [32i+31:32i]
- `req_e_index`  in  32*NREQ  end index (inclusive), same packing
- `req_ready`  out  NREQ  one-hot, combinational grant; job accepted on a cycle where `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  NREQ  one-hot, one-cycle response pulse to the job owner
- `rsp_value`  out  32  job result, valid while `rsp_valid` is nonzero
- `rsp_err`  out  1  job rejected (`e_index < s_index`), qualified by `rsp_valid`
- `mem_rd`  out  1  memory read strobe
- `mem_addr`  out  32  read index
- `mem_data`  in  32  read data, valid exactly 1 cycle after `mem_rd`
- `op_clr`  out  1  one-cycle clear of the op accumulator
- `op_en`  out  1  op consumes `op_data` this cycle
- `op_data`  out  32  equals `mem_data` (combinational pass-through)
- `op_result`  in  32  op output, valid the cycle after its last `op_en`
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, CLR, RUN, DRAIN, CAPT, RESP, ERR.
- IDLE:
  - `req_ready` is the arbitration winner among asserted `req_valid` bits; it is 0 if none is asserted.
  - On accept, latch the owner, `s`, and `e`; set `cnt = s`.
  - If `e < s` (unsigned), go to ERR; otherwise go to CLR.
- CLR: `op_clr = 1` for one cycle, then RUN.
- RUN:
  - Each cycle: `mem_rd = 1`, `mem_addr = cnt`, `cnt = cnt + 1`.
  - When `mem_addr == e`, go to DRAIN.
  - No wrap handling is needed because `e >= s` is guaranteed.
  - `op_en` is a 1-cycle delayed copy of `mem_rd`.
- DRAIN: the last `op_en` occurs. No `mem_rd`. Then CAPT.
- CAPT: register `op_result` into `rsp_value`. Then RESP.
- RESP: `rsp_valid[owner] = 1`, `rsp_err = 0`. Then IDLE.
- ERR: `rsp_valid[owner] = 1`, `rsp_err = 1`, `rsp_value = 0`. No `op_clr`, `mem_rd` or `op_en`. Then IDLE.
- Grants occur only in IDLE; `req_ready` is 0 in every other state.
- Requesters hold `req_valid` and their indices stable until accepted. Dropping `req_valid` before grant withdraws the job with no side effects.
- Arbitration: the priority pointer starts at `last_grant + 1` (mod NREQ). `last_grant` resets to NREQ-1, so requester 0 has first priority. `last_grant` updates only on accept.
- Reset values: `req_ready = 0` whenever no `req_valid` is asserted. `rsp_valid = 0`, `rsp_value = 0`, `rsp_err = 0`, `mem_rd = 0`, `mem_addr = 0`, `op_clr = 0`, `op_en = 0`, `busy = 0`. State is IDLE, `last_grant = NREQ-1`.
- Reset mid-job: the job is abandoned and no response is issued. The requester must resubmit.

## Timing
- Accept at cycle 0; window length `L = e - s + 1`.
- Cycle 1: `op_clr`.
- Cycles 2..L+1: `mem_rd`, with addresses s..e.
- Cycles 3..L+2: `op_en`.
- Cycle L+3: capture.
- Cycle L+4: `rsp_valid`.
- Earliest next grant: cycle L+5. Accept-to-response latency is L+4 cycles.
- Error job: `rsp_valid` at cycle 1, next grant at cycle 2.
- `op_en` for element k coincides with `mem_data` for element k. There are no bubbles inside a window.

## Configuration
- `ITER_SCHED_RR_EN` defined: round-robin arbitration as above.
- `ITER_SCHED_RR_EN` undefined: fixed priority, lowest asserted index wins. `last_grant` is not implemented. Timing is otherwise identical.

## Test plan
- Single job, req 0, s=10, e=13, op = sum, mem[i]=i: `op_clr` at cycle 1; `mem_addr` 10,11,12,13 in cycles 2-5; `op_en` in cycles 3-6; `rsp_valid = 4'b0001` at cycle 8 with `rsp_value = 46`, `rsp_err = 0`.
- Length-1 window, s=e=7, mem[7]=0x55: one `mem_rd`, one `op_en`; `rsp_value = 0x55` at cycle 5.
- Error job, req 2, s=20, e=19: `rsp_valid = 4'b0100` and `rsp_err = 1` at cycle 1; no `op_clr`, `mem_rd` or `op_en`; a new grant is possible at cycle 2.
- All four requesters held valid continuously (RR build): grant order 0,1,2,3,0. In the fixed-priority build, only requester 0 is granted while it stays valid.
- Rst pulled low during RUN for L=16: all outputs zero immediately; after release, no `rsp_valid` for the dropped job; a resubmitted job completes normally.
- Back-to-back jobs, req 1 (s=0, e=2) then req 3 (s=5, e=5): second grant at cycle 8; responses at cycle 7 and cycle 13.
